// File: rtl/cpu7_ifu_ibuf_if.sv
// Purpose : fetch-to-decode handshake bundle for the instruction buffer.
// Latency : n/a (wires only).
// Backpressure: f_allow throttles fetch; d_ready from decode pops the head.
// Ports   : fetch side f_valid/f_pc/f_inst/f_ex/f_exccode/f_allow, flush,
//           decode side d_valid/d_pc/d_inst/d_ex/d_exccode/d_ready, count.
//           master = fetch/decode environment, slave = the buffer.
interface cpu7_ifu_ibuf_if #(
    parameter int PTR_W = 2
);
    logic             f_valid;
    logic [31:0]      f_pc;
    logic [31:0]      f_inst;
    logic             f_ex;
    logic [5:0]       f_exccode;
    logic             f_allow;
    logic             flush;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_inst;
    logic             d_ex;
    logic [5:0]       d_exccode;
    logic             d_ready;
    logic [PTR_W:0]   count;

    modport master (
        output f_valid, f_pc, f_inst, f_ex, f_exccode, flush, d_ready,
        input  f_allow, d_valid, d_pc, d_inst, d_ex, d_exccode, count
    );

    modport slave (
        input  f_valid, f_pc, f_inst, f_ex, f_exccode, flush, d_ready,
        output f_allow, d_valid, d_pc, d_inst, d_ex, d_exccode, count
    );
endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// Purpose : small circular instruction FIFO between fetch and decode, flushed on branch cancel.
// Latency : 1 cycle push-to-head (0 cycles into an empty buffer when CPU7_IFU_IBUF_BYPASS_EN is defined).
// Backpressure: f_allow = not full, from registered state only; a full buffer refuses a push even if it pops.
// Ports   : clock, reset (synchronous, active-high), bus (cpu7_ifu_ibuf_if.slave).
// Option  : define CPU7_IFU_IBUF_BYPASS_EN to forward fetch straight to decode while empty.
module cpu7_ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu7_ifu_ibuf_if.slave       bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [5:0]  exccode;
    } ibuf_ent_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    ibuf_ent_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    ibuf_ent_t        wr_ent;
    ibuf_ent_t        hd_ent;
    logic             empty;
    logic             push;
    logic             pop;
    logic             byp;

    // Faulting fetches carry no meaningful instruction word; store zero.
    always_comb begin
        wr_ent         = '0;
        wr_ent.pc      = bus.f_pc;
        wr_ent.inst    = bus.f_ex ? 32'h0 : bus.f_inst;
        wr_ent.ex      = bus.f_ex;
        wr_ent.exccode = bus.f_exccode;
    end

    assign empty       = (cnt_q == '0);
    assign bus.f_allow = (cnt_q != FULL_CNT);

`ifdef CPU7_IFU_IBUF_BYPASS_EN
    logic fwd;
    // While empty, fetch is shown directly on the head; it is only consumed
    // without a write when decode takes it in the same cycle.
    assign fwd         = empty & bus.f_valid & ~bus.flush;
    assign byp         = fwd & bus.d_ready;
    assign hd_ent      = fwd ? wr_ent : mem_q[rp_q];
    assign bus.d_valid = ~empty | fwd;
`else
    assign byp         = 1'b0;
    assign hd_ent      = mem_q[rp_q];
    assign bus.d_valid = ~empty;
`endif

    assign push = bus.f_valid & bus.f_allow & ~bus.flush & ~byp;
    // Pop only real stored entries; a bypassed instruction never occupies a slot.
    assign pop  = ~empty & bus.d_ready & ~bus.flush;

    assign bus.d_pc      = hd_ent.pc;
    assign bus.d_inst    = hd_ent.inst;
    assign bus.d_ex      = hd_ent.ex;
    assign bus.d_exccode = hd_ent.exccode;
    assign bus.count     = cnt_q;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (bus.flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_W'(1);
            if (pop)  rp_d = rp_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset; push is already gated by flush.
    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wp_q] <= wr_ent;
    end
endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
module tb_cpu7_ifu_ibuf;
    logic clock;
    logic reset;

    cpu7_ifu_ibuf_if #(.PTR_W(2)) bus ();

    cpu7_ifu_ibuf #(.DEPTH(4), .PTR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ex;
        logic [5:0]  exccode;
    } ent_t;

    ent_t exp_q [$];
    int   cnt_m   = 0;
    int   total   = 0;
    int   bad     = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; expected outputs enter the scoreboard as the
    // stimulus is issued, the model count advances after the edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ex, input logic [5:0] code, input logic dr, input logic fl);
        bit   acc, popm, bypm;
        ent_t e;
        int   nc;
        bus.f_valid   = fv;
        bus.f_pc      = pc;
        bus.f_inst    = inst;
        bus.f_ex      = ex;
        bus.f_exccode = code;
        bus.d_ready   = dr;
        bus.flush     = fl;
        acc  = fv && !fl && (cnt_m != 4);
`ifdef CPU7_IFU_IBUF_BYPASS_EN
        bypm = fv && dr && !fl && (cnt_m == 0);
`else
        bypm = 1'b0;
`endif
        popm = dr && !fl && (cnt_m != 0);
        if (acc) begin
            e.pc = pc; e.inst = ex ? 32'h0 : inst; e.ex = ex; e.exccode = code;
            exp_q.push_back(e);
        end
        nc = cnt_m;
        if (fl)         nc = 0;
        else if (!bypm) nc = cnt_m + (acc ? 1 : 0) - (popm ? 1 : 0);
        @(posedge clock);
        #1;
        cnt_m = nc;
        if (fl) exp_q.delete();
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, dr, 1'b0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        bus.f_valid = 1'b0; bus.d_ready = 1'b0; bus.flush = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        cnt_m = 0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    // Monitor: checks state flags every cycle and head contents whenever valid.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            logic exp_dv;
            ent_t e;
            exp_dv = (cnt_m != 0);
`ifdef CPU7_IFU_IBUF_BYPASS_EN
            exp_dv = exp_dv || (bus.f_valid && !bus.flush && cnt_m == 0);
`endif
            chk("count", 32'(bus.count), 32'(cnt_m));
            chk("f_allow", 32'(bus.f_allow), 32'(cnt_m != 4));
            chk("d_valid", 32'(bus.d_valid), 32'(exp_dv));
            if (bus.d_valid && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_head", 32'(1), 32'(0));
                end else begin
                    e = exp_q[0];
                    chk("d_pc", bus.d_pc, e.pc);
                    chk("d_inst", bus.d_inst, e.inst);
                    chk("d_ex", 32'(bus.d_ex), 32'(e.ex));
                    chk("d_exccode", 32'(bus.d_exccode), 32'(e.exccode));
                    if (bus.d_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.f_valid = 1'b0; bus.f_pc = '0; bus.f_inst = '0; bus.f_ex = 1'b0;
        bus.f_exccode = '0; bus.d_ready = 1'b0; bus.flush = 1'b0;
        do_reset();
        chk("rst_d_valid", 32'(bus.d_valid), 32'(0));
        chk("rst_f_allow", 32'(bus.f_allow), 32'(1));
        chk("rst_count", 32'(bus.count), 32'(0));

        // Streaming with decode always ready.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1c000000 + 32'(4*i), 32'h00100000 + 32'(i), 1'b0, 6'h0, 1'b1, 1'b0);
        idle(1'b1);
        chk("stream_drained", 32'(bus.count), 32'(0));

        // Fill with decode stalled; fifth is refused.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h1c000100 + 32'(4*i), 32'h00200000 + 32'(i), 1'b0, 6'h0, 1'b0, 1'b0);
            if (i == 3) begin
                chk("full_count", 32'(bus.count), 32'(4));
                chk("full_allow", 32'(bus.f_allow), 32'(0));
            end
        end
        chk("fifth_refused", 32'(bus.count), 32'(4));
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drain_count", 32'(bus.count), 32'(0));
        chk("drain_valid", 32'(bus.d_valid), 32'(0));

        // Full plus simultaneous push attempt and pop.
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1c000200 + 32'(4*i), 32'h00300000 + 32'(i), 1'b0, 6'h0, 1'b0, 1'b0);
        step(1'b1, 32'h1c000210, 32'h00300004, 1'b0, 6'h0, 1'b1, 1'b0);
        chk("full_pop_count", 32'(bus.count), 32'(3));
        chk("full_pop_allow", 32'(bus.f_allow), 32'(1));

        // Flush with a concurrent push: nothing survives.
        step(1'b1, 32'hbad0bad0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b1);
        chk("flush_count", 32'(bus.count), 32'(0));
        chk("flush_valid", 32'(bus.d_valid), 32'(0));
        chk("flush_allow", 32'(bus.f_allow), 32'(1));

        // Exception entry: instruction word forced to zero.
        step(1'b1, 32'h1c000300, 32'hdeadbeef, 1'b1, 6'h08, 1'b0, 1'b0);
        chk("exc_d_inst", bus.d_inst, 32'h0);
        chk("exc_d_ex", 32'(bus.d_ex), 32'(1));
        chk("exc_d_exccode", 32'(bus.d_exccode), 32'h08);
        idle(1'b1);

        // Interleaved push/pop across pointer wrap, count in 1..3.
        begin
            logic [9:0] fv_v = 10'b1101011111;
            logic [9:0] dr_v = 10'b0111101100;
            for (int i = 0; i < 10; i++)
                step(fv_v[i], 32'h1c000400 + 32'(4*i), 32'h00400000 + 32'(i), 1'b0, 6'(i),
                     dr_v[i], 1'b0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("wrap_drained", 32'(bus.count), 32'(0));

        // Reset mid-operation discards contents.
        step(1'b1, 32'h1c000500, 32'h1, 1'b0, 6'h0, 1'b0, 1'b0);
        step(1'b1, 32'h1c000504, 32'h2, 1'b0, 6'h0, 1'b0, 1'b0);
        do_reset();
        chk("midrst_count", 32'(bus.count), 32'(0));
        chk("midrst_valid", 32'(bus.d_valid), 32'(0));

`ifdef CPU7_IFU_IBUF_BYPASS_EN
        // Zero-latency forward into an empty buffer.
        bus.f_valid = 1'b1; bus.f_pc = 32'h1c000600; bus.f_inst = 32'h77;
        bus.f_ex = 1'b0; bus.f_exccode = '0; bus.d_ready = 1'b1; bus.flush = 1'b0;
        #1;
        chk("byp_d_pc", bus.d_pc, 32'h1c000600);
        chk("byp_d_valid", 32'(bus.d_valid), 32'(1));
        step(1'b1, 32'h1c000600, 32'h77, 1'b0, 6'h0, 1'b1, 1'b0);
        chk("byp_count", 32'(bus.count), 32'(0));
`endif

        idle(1'b0);
        mon_en = 1'b0;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
